// File: rtl/hid_mp_if.sv
// MCU-side byte bus of the HID block: framed byte stream in, reply byte and
// DB9-change interrupt out.
`timescale 1ns/1ps

interface hid_mp_if;
   logic       data_in_strobe;
   logic       data_in_start;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       irq;
   logic       iack;

   modport master (
      output data_in_strobe, data_in_start, data_in, iack,
      input  data_out, irq
   );

   modport slave (
      input  data_in_strobe, data_in_start, data_in, iack,
      output data_out, irq
   );
endinterface

// File: rtl/hid_mp.sv
// Multi-port HID block: decodes the IO-MCU command stream into keyboard,
// joystick, mouse and numpad state, and reports local DB9 ports back to the MCU.
`timescale 1ns/1ps

module hid_mp #(
   parameter int NUM_JOY  = 2,
   parameter int NUM_DB9  = 2,
   parameter int DB9_W    = 6,
   parameter int KBD_ROWS = 8,
   parameter int KBD_COLS = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   hid_mp_if.slave                  mcu,
   input  logic [NUM_DB9*DB9_W-1:0] db9_port,
   input  logic [KBD_ROWS-1:0]      keyboard_matrix_out,
   output logic [KBD_COLS-1:0]      keyboard_matrix_in,
   output logic [NUM_JOY*8-1:0]     joystick,
   output logic [NUM_JOY*8-1:0]     joystick_ax,
   output logic [NUM_JOY*8-1:0]     joystick_ay,
   output logic [NUM_JOY*8-1:0]     joystick_extra,
   output logic [NUM_JOY-1:0]       joystick_strobe,
   output logic [7:0]               numpad,
   output logic                     mod_key,
   output logic                     key_restore,
   output logic                     tape_play,
   output logic [1:0]               mouse_btns,
   output logic [7:0]               mouse_x,
   output logic [7:0]               mouse_y,
   output logic                     mouse_strobe,
   input  logic                     mouse_ack
);

   localparam int DBW = NUM_DB9 * DB9_W;
   localparam int JW  = NUM_JOY * 8;

   localparam logic [7:0] CMD_STATUS = 8'd0;
   localparam logic [7:0] CMD_KBD    = 8'd1;
   localparam logic [7:0] CMD_MOUSE  = 8'd2;
   localparam logic [7:0] CMD_JOY    = 8'd3;
   localparam logic [7:0] CMD_DB9    = 8'd4;
   localparam logic [7:0] DEV_NUMPAD = 8'h80;

   logic [3:0]  state_q, state_d;
   logic [7:0]  command_q, command_d;
   logic [7:0]  data_out_q, data_out_d;
   logic [7:0]  row_q, row_d;
   logic [KBD_ROWS-1:0][KBD_COLS-1:0] kbd_q, kbd_d;
   logic [7:0]  dx_q, dx_d;
   logic [1:0]  btns_q, btns_d;
   logic [7:0]  mx_q, mx_d;
   logic [7:0]  my_q, my_d;
   logic        mstb_q, mstb_d;
   logic [7:0]  dev_q, dev_d;
   logic [JW-1:0] joy_q, joy_d;
   logic [JW-1:0] ax_q, ax_d;
   logic [JW-1:0] ay_q, ay_d;
   logic [JW-1:0] ex_q, ex_d;
   logic [NUM_JOY-1:0] jstb_q, jstb_d;
   logic [7:0]  numpad_q, numpad_d;
   logic [DBW-1:0] sync1_q, sync1_d;
   logic [DBW-1:0] sync2_q, sync2_d;
   logic [DBW-1:0] prev_q, prev_d;
   logic [NUM_DB9-1:0] change_q, change_d;
   logic        irq_q, irq_d;
   logic        irq_en_q, irq_en_d;

   logic        byte_ok;
   logic        irq_fire;
   logic [NUM_DB9-1:0] db9_diff;
   logic [NUM_DB9-1:0] db9_clear;
   logic [7:0]  flag_byte;
   logic [7:0]  port_byte [NUM_DB9];

   // Signed 8-bit add evaluated in 9 bits, clamped to [-128, +127].
   function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s;
      s = {a[7], a} + {b[7], b};
      if (s[8] != s[7])
         sat_add = s[8] ? 8'h80 : 8'h7F;
      else
         sat_add = s[7:0];
   endfunction

   assign byte_ok  = mcu.data_in_strobe && !mcu.data_in_start && (state_q != 4'd0);
   assign irq_fire = irq_en_q && (|change_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= '0;
         command_q  <= '0;
         data_out_q <= '0;
         row_q      <= '0;
         kbd_q      <= '1;
         dx_q       <= '0;
         btns_q     <= '0;
         mx_q       <= '0;
         my_q       <= '0;
         mstb_q     <= 1'b0;
         dev_q      <= '0;
         joy_q      <= '0;
         ax_q       <= '0;
         ay_q       <= '0;
         ex_q       <= '0;
         jstb_q     <= '0;
         numpad_q   <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         prev_q     <= '0;
         change_q   <= '0;
         irq_q      <= 1'b0;
         irq_en_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         command_q  <= command_d;
         data_out_q <= data_out_d;
         row_q      <= row_d;
         kbd_q      <= kbd_d;
         dx_q       <= dx_d;
         btns_q     <= btns_d;
         mx_q       <= mx_d;
         my_q       <= my_d;
         mstb_q     <= mstb_d;
         dev_q      <= dev_d;
         joy_q      <= joy_d;
         ax_q       <= ax_d;
         ay_q       <= ay_d;
         ex_q       <= ex_d;
         jstb_q     <= jstb_d;
         numpad_q   <= numpad_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         prev_q     <= prev_d;
         change_q   <= change_d;
         irq_q      <= irq_d;
         irq_en_q   <= irq_en_d;
      end
   end

   // A start byte restarts framing unconditionally; payload bytes advance a
   // position counter that parks at 15 so long packets stay in a defined state.
   always_comb begin
      state_d   = state_q;
      command_d = command_q;
      if (mcu.data_in_strobe && mcu.data_in_start) begin
         command_d = mcu.data_in;
         state_d   = 4'd1;
      end else if (byte_ok) begin
         state_d = (state_q == 4'd15) ? 4'd15 : state_q + 4'd1;
      end
   end

   always_comb begin
      flag_byte = '0;
      flag_byte[NUM_DB9-1:0] = change_q;
      for (int k = 0; k < NUM_DB9; k++) begin
         port_byte[k] = '0;
         port_byte[k][DB9_W-1:0] = sync2_q[k*DB9_W +: DB9_W];
         db9_diff[k] = |(sync2_q[k*DB9_W +: DB9_W] ^ prev_q[k*DB9_W +: DB9_W]);
      end
   end

   always_comb begin
      data_out_d = data_out_q;
      row_d      = row_q;
      kbd_d      = kbd_q;
      dx_d       = dx_q;
      btns_d     = btns_q;
      mx_d       = mx_q;
      my_d       = my_q;
      mstb_d     = 1'b0;
      dev_d      = dev_q;
      joy_d      = joy_q;
      ax_d       = ax_q;
      ay_d       = ay_q;
      ex_d       = ex_q;
      jstb_d     = '0;
      numpad_d   = numpad_q;
      db9_clear  = '0;
      irq_en_d   = irq_fire ? 1'b0 : irq_en_q;
      sync1_d    = db9_port;
      sync2_d    = sync1_q;
      prev_d     = sync2_q;

      // The ack clears first, so a coincident packet lands on a zero base.
      if (mouse_ack) begin
         mx_d = '0;
         my_d = '0;
      end

      if (byte_ok) begin
         case (command_q)
            CMD_STATUS: begin
               case (state_q)
                  4'd1:    data_out_d = 8'h5C;
                  4'd2:    data_out_d = 8'h43;
                  4'd3:    data_out_d = 8'(NUM_JOY);
                  4'd4:    data_out_d = {4'(NUM_DB9), 4'(KBD_COLS - 1)};
                  default: data_out_d = data_out_q;
               endcase
            end
            CMD_KBD: begin
               if (state_q == 4'd1) begin
                  row_d = mcu.data_in;
               end else if (state_q == 4'd2) begin
                  for (int r = 0; r < KBD_ROWS; r++)
                     for (int c = 0; c < KBD_COLS; c++)
                        if (row_q == 8'(r) && mcu.data_in[6:0] == 7'(c))
                           kbd_d[r][c] = mcu.data_in[7];
               end
            end
            CMD_MOUSE: begin
               case (state_q)
                  4'd1: btns_d = mcu.data_in[1:0];
                  4'd2: dx_d   = mcu.data_in;
                  4'd3: begin
                     mx_d   = sat_add(mx_d, dx_q);
                     my_d   = sat_add(my_d, mcu.data_in);
                     mstb_d = 1'b1;
                  end
                  default: mstb_d = 1'b0;
               endcase
            end
            CMD_JOY: begin
               if (state_q == 4'd1) begin
                  dev_d = mcu.data_in;
               end else begin
                  for (int j = 0; j < NUM_JOY; j++) begin
                     if (dev_q == 8'(j)) begin
                        case (state_q)
                           4'd2: joy_d[j*8 +: 8] = mcu.data_in;
                           4'd3: ax_d[j*8 +: 8]  = mcu.data_in;
                           4'd4: ay_d[j*8 +: 8]  = mcu.data_in;
                           4'd5: begin
                              ex_d[j*8 +: 8] = mcu.data_in;
                              jstb_d[j]      = 1'b1;
                           end
                           default: jstb_d[j] = 1'b0;
                        endcase
                     end
                  end
                  if (dev_q == DEV_NUMPAD && state_q == 4'd2)
                     numpad_d = mcu.data_in;
               end
            end
            CMD_DB9: begin
               if (state_q == 4'd1) begin
                  irq_en_d   = 1'b1;
                  data_out_d = flag_byte;
               end else if (state_q > 4'(NUM_DB9 + 1)) begin
                  data_out_d = 8'h00;
               end else begin
                  for (int k = 0; k < NUM_DB9; k++) begin
                     if (state_q == 4'(k + 2)) begin
                        data_out_d   = port_byte[k];
                        db9_clear[k] = 1'b1;
                     end
                  end
               end
            end
            default: data_out_d = data_out_q;
         endcase
      end

      change_d = (change_q & ~db9_clear) | db9_diff;

      if (irq_fire)
         irq_d = 1'b1;
      else if (mcu.iack)
         irq_d = 1'b0;
      else
         irq_d = irq_q;
   end

   // Column sense: a pressed key (0) on any driven row pulls its column low.
   always_comb begin
      keyboard_matrix_in = '1;
      for (int r = 0; r < KBD_ROWS; r++)
         if (!keyboard_matrix_out[r])
            keyboard_matrix_in = keyboard_matrix_in & kbd_q[r];
   end

   assign mcu.data_out      = data_out_q;
   assign mcu.irq           = irq_q;
   assign joystick          = joy_q;
   assign joystick_ax       = ax_q;
   assign joystick_ay       = ay_q;
   assign joystick_extra    = ex_q;
   assign joystick_strobe   = jstb_q;
   assign numpad            = numpad_q;
   assign mod_key           = numpad_q[5];
   assign key_restore       = numpad_q[6];
   assign tape_play         = numpad_q[7];
   assign mouse_btns        = btns_q;
   assign mouse_x           = mx_q;
   assign mouse_y           = my_q;
   assign mouse_strobe      = mstb_q;

endmodule

// File: doc/hid_mp.md
Name: hid_mp

Overview:
- Parametrised multi-port successor of the core's HID/MCU interface block.
- Decodes the IO-MCU byte stream into the following core-side outputs:
  - a generic keyboard matrix;
  - N digital/analog joysticks;
  - an accumulated, saturating mouse delta;
  - numpad/special keys.
- Reports M local DB9 ports back to the MCU, with per-port sticky change flags and an interrupt.
- Sits between the MCU SPI byte layer and the machine core.

Parameters:
- NUM_JOY, 2, number of USB joystick channels (1..4).
- NUM_DB9, 2, number of local DB9 ports reported to MCU (1..4).
- DB9_W, 6, bits per DB9 port (1..8).
- KBD_ROWS, 8, keyboard matrix rows (1..16).
- KBD_COLS, 8, keyboard matrix columns (1..8).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- data_in_strobe  in  1  one-cycle pulse: data_in valid.
- data_in_start  in  1  qualifies strobe: byte is a command byte.
- data_in  in  8  MCU byte.
- data_out  out  8  registered reply byte, sampled by the MCU on the next strobe.
- db9_port  in  NUM_DB9*DB9_W  local ports, port k at [k*DB9_W +: DB9_W], asynchronous.
- irq  out  1  DB9-change interrupt to MCU.
- iack  in  1  interrupt acknowledge pulse.
- keyboard_matrix_out  in  KBD_ROWS  row drive, active low.
- keyboard_matrix_in  out  KBD_COLS  column sense, active low, combinational.
- joystick  out  NUM_JOY*8  digital state, channel j at [j*8+:8].
- joystick_ax / joystick_ay / joystick_extra  out  NUM_JOY*8 each  analog axes and extra buttons.
- joystick_strobe  out  NUM_JOY  per-channel update pulse.
- numpad  out  8  numpad byte.
- mod_key / key_restore / tape_play  out  1 each  numpad bits 5/6/7.
- mouse_btns  out  2  mouse buttons.
- mouse_x / mouse_y  out  8  signed accumulated deltas.
- mouse_strobe  out  1  accumulator-updated pulse.
- mouse_ack  in  1  core consumed deltas; clears accumulators.

Behaviour:
- Reset (reset_n low, async):
  - state=0, command=0, data_out=0x00, irq=0, irq_enable=0, change flags=0.
  - All keyboard bits=1 (released).
  - joystick/ax/ay/extra/numpad/mouse outputs=0; all strobes=0.
  - db9 synchroniser loaded from 0.
- Reset mid-transfer aborts the transfer; the next non-start byte is ignored.
- Byte framing:
  - strobe with start: command<=data_in, state<=1. Start always restarts, whatever the current state.
  - strobe without start and state!=0: handle byte per command, then state<=state+1, saturating at 15.
  - state 0: byte ignored.
  - Unknown commands: bytes ignored, data_out unchanged.
  - Strobes are single-cycle pulses; all strobe outputs are single-cycle, registered on the cycle after the qualifying data_in_strobe.
- CMD 0 (status): data_out at state 1..4 = 0x5C, 0x43, NUM_JOY, {NUM_DB9[3:0], KBD_COLS-1[3:0]}.
- CMD 1 (keyboard):
  - state1: row<=data_in.
  - state2: if row<KBD_ROWS and data_in[6:0]<KBD_COLS, keyboard[row][data_in[6:0]]<=data_in[7] (1=released). Otherwise ignored.
  - keyboard_matrix_in[c] = AND over rows r with keyboard_matrix_out[r]==0 of keyboard[r][c]. No row driven gives all 1.
- CMD 2 (mouse):
  - state1: mouse_btns<=data_in[1:0].
  - state2: latch dx.
  - state3: mouse_x<=sat(mouse_x+dx), mouse_y<=sat(mouse_y+data_in); mouse_strobe=1.
  - Arithmetic is 9-bit signed, saturating to [-128,+127].
  - mouse_ack clears the accumulators to 0. If mouse_ack coincides with the state3 update, result = new delta alone (ack applied first).
- CMD 3 (joystick):
  - state1: device<=data_in.
  - For device j<NUM_JOY: state2 joystick[j], state3 ax[j], state4 ay[j], state5 extra[j] with joystick_strobe[j]=1.
  - device 0x80, state2: numpad<=data_in; mod_key/key_restore/tape_play<=data_in[5]/[6]/[7].
  - Any other device: ignored.
- DB9 monitoring:
  - db9_port is double-flop synchronised, then compared against the previous synchronised value.
  - A per-port difference sets change[k] (sticky).
  - irq<=1 when irq_enable and any change bit is set; irq_enable then drops to 0.
  - iack clears irq (set has priority if both occur in the same cycle).
- CMD 4 (DB9 read):
  - state1: irq_enable<=1; data_out<=change flags (zero-extended).
  - state k+2 (k<NUM_DB9): data_out<={zero-pad, port k}, and change[k] cleared. A change detected in the same cycle keeps change[k]=1.
  - States beyond NUM_DB9+1: data_out=0x00.

Test Plan:
- Reset, then CMD0 + 4 dummy bytes → data_out sequence 0x5C, 0x43, 0x02, 0x27 (NUM_DB9=2, KBD_COLS=8).
- CMD1 row=3, byte 0x05 (press col5), drive keyboard_matrix_out=0xF7 → keyboard_matrix_in=0xDF.
  - Then byte 0x85 → 0xFF.
  - Row=9 → no change.
- CMD2: three packets dx=+100 → mouse_x 100, 127, 127.
  - Then mouse_ack → 0.
  - Ack coincident with dx=-5 → -5 (0xFB).
- CMD3 device 1: bytes 0x11, 0x22, 0x33, 0x44 → joystick[15:8]=0x11, ax=0x22, ay=0x33, extra=0x44, joystick_strobe=2'b10 for one cycle.
  - device 0x80 byte 0xE0 → mod_key, key_restore, tape_play all 1.
- CMD4 to enable, then toggle db9 port1 bit0 → irq rises within 4 cycles.
  - iack clears irq.
  - CMD4 read → change byte 0x02, then port0, port1 values; change flags cleared; irq stays 0 until the next change.
- Assert reset_n low mid-CMD3 (after device byte) → all outputs return to reset values asynchronously; the following payload byte without start is ignored.
